// File: rtl/step_ctrl_if.sv
// Switch/button and step-strobe bundle between the switch side and step_ctrl.
//   time_s, up, hold, sstep : raw slide switches and buttons (into step_ctrl)
//   step_en, step_up        : one-tick step strobe and committed direction
//   dir_chg                 : one-tick pulse on each committed direction change
//   running, fast           : run/pause status and debounced rate switch
// master = switch/board side, slave = step_ctrl.
interface step_ctrl_if;
  logic time_s;
  logic up;
  logic hold;
  logic sstep;
  logic step_en;
  logic step_up;
  logic dir_chg;
  logic running;
  logic fast;

  modport master (
    output time_s, up, hold, sstep,
    input  step_en, step_up, dir_chg, running, fast
  );

  modport slave (
    input  time_s, up, hold, sstep,
    output step_en, step_up, dir_chg, running, fast
  );
endinterface

// File: rtl/step_ctrl.sv
// Upstream step controller for the sequence-display datapath (2 Hz domain).
// Conditions the raw switches/buttons and issues one-tick step strobes with a
// committed direction. All rate, pause, single-step and direction-turn policy
// lives here; the downstream stepper only advances on step_en.
//   clk_500ms : step-domain clock (2 Hz tick)
//   reset     : asynchronous, active-high reset
//   bus       : step_ctrl_if.slave (raw inputs in, step/status outputs out)
//   SLOW_DIV  : ticks per step in slow mode (>= 2)
module step_ctrl #(
  parameter int SLOW_DIV = 2
) (
  input logic         clk_500ms,
  input logic         reset,
  step_ctrl_if.slave  bus
);

  localparam int PW = $clog2(SLOW_DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SLOW_DIV - 1);

  // Conditioning vector bit order: [3]=time_s [2]=up [1]=hold [0]=sstep.
  // Only the direction switch idles high out of reset.
  localparam logic [3:0] COND_RST = 4'b0100;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TURN,
    ST_PAUSE
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    s0, s1, deb;
  logic [1:0]    deb_d;
  logic [1:0]    settle_cnt;
  logic          settle_done;
  logic          hold_rise, sstep_rise;
  logic          deb_fast, deb_up, dir_diff;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic          step_en_r, step_en_n;
  logic          step_up_r, step_up_n;
  logic          dir_chg_r, dir_chg_n;
  logic          running_r;

  assign raw = {bus.time_s, bus.up, bus.hold, bus.sstep};

  assign deb_fast    = deb[3];
  assign deb_up      = deb[2];
  assign hold_rise   = deb[1] & ~deb_d[1];
  assign sstep_rise  = deb[0] & ~deb_d[0];
  assign dir_diff    = (deb_up != step_up_r);
  // The FSM stays frozen until the conditioning chain has had three edges to
  // flush its reset values, so no step can fire on stale switch state.
  assign settle_done = (settle_cnt == 2'd3);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let s1 see the new s0 in the same edge.
  always_ff @(posedge clk_500ms or posedge reset) begin
    if (reset) begin
      s0         <= COND_RST;
      s1         <= COND_RST;
      deb        <= COND_RST;
      deb_d      <= 2'b00;
      settle_cnt <= 2'd0;
    end else begin
      s0         <= raw;
      s1         <= s0;
      // A bit only updates once two consecutive samples agree.
      for (int i = 0; i < 4; i++) begin
        if (s0[i] == s1[i]) deb[i] <= s1[i];
      end
      deb_d      <= deb[1:0];
      if (!settle_done) settle_cnt <= settle_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_500ms or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      phase     <= '0;
      step_en_r <= 1'b0;
      step_up_r <= 1'b1;
      dir_chg_r <= 1'b0;
      running_r <= 1'b1;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      step_en_r <= step_en_n;
      step_up_r <= step_up_n;
      dir_chg_r <= dir_chg_n;
      running_r <= (state_n != ST_PAUSE);
    end
  end

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    step_en_n = 1'b0;
    step_up_n = step_up_r;
    dir_chg_n = 1'b0;

    if (settle_done) begin
      case (state)
        ST_RUN: begin
          if (hold_rise) begin
            // Pause wins over a turn, but a pending direction is still committed.
            state_n = ST_PAUSE;
            phase_n = '0;
            if (dir_diff) begin
              step_up_n = deb_up;
              dir_chg_n = 1'b1;
            end
          end else if (dir_diff) begin
            state_n   = ST_TURN;
            phase_n   = '0;
            step_up_n = deb_up;
            dir_chg_n = 1'b1;
          end else begin
            // Phase keeps counting in fast mode so a switch to slow mode lands
            // on the existing cadence rather than restarting it.
            phase_n   = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
            step_en_n = deb_fast || (phase == PHASE_LAST);
          end
        end

        ST_TURN: begin
          phase_n = '0;
          state_n = hold_rise ? ST_PAUSE : ST_RUN;
        end

        ST_PAUSE: begin
          phase_n = '0;
          // Direction is committed first so a same-tick single step uses it.
          if (dir_diff) begin
            step_up_n = deb_up;
            dir_chg_n = 1'b1;
          end
          if (hold_rise) state_n = ST_RUN;
          else if (sstep_rise) step_en_n = 1'b1;
        end

        default: begin
          state_n = ST_RUN;
          phase_n = '0;
        end
      endcase
    end
  end

  assign bus.step_en = step_en_r;
  assign bus.step_up = step_up_r;
  assign bus.dir_chg = dir_chg_r;
  assign bus.running = running_r;
  assign bus.fast    = deb_fast;

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
Upstream step controller for the sequence-display datapath. It runs in the divided 2 Hz domain, conditions the raw slide switches and buttons, and issues one-tick step strobes with a direction. The downstream sequence stepper advances its position only on step_en, so all rate, pause, single-step and direction-turn policy lives here.

Parameters:
SLOW_DIV, 2, clk_500ms ticks per step in slow mode (integer >= 2)

Ports:
clk_500ms  input  1  step-domain clock (2 Hz tick)
reset  input  1  asynchronous, active-high reset
time_s  input  1  raw rate switch: 1 = fast (step every tick), 0 = slow (step every SLOW_DIV ticks)
up  input  1  raw direction switch: 1 = up, 0 = down
hold  input  1  raw pause/run toggle button, active-high
sstep  input  1  raw single-step button, active-high, honoured only while paused
step_en  output  1  one-tick step strobe to the sequence stepper
step_up  output  1  committed direction, valid whenever step_en = 1
dir_chg  output  1  one-tick pulse on every committed direction change
running  output  1  1 in RUN/TURN, 0 in PAUSE
fast  output  1  debounced time_s

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk_500ms. All state and outputs are registered on posedge clk_500ms.
- Reset values: step_en=0, step_up=1, dir_chg=0, running=1, fast=0, state=RUN, phase=0. Debounced up resets to 1; debounced time_s, hold and sstep reset to 0. Synchronizer flops take the same values as their debounced signals.
- Conditioning, per input x in {time_s, up, hold, sstep}:
  - Chain: s0<=x; s1<=s0; deb<=(s0==s1)?s1:deb.
  - An input held stable before edge k through edge k+2 shows on deb at edge k+2.
  - The FSM reacts at edge k+3.
- Edge detection: hold_rise and sstep_rise are each deb & ~deb_d, where deb_d is a one-tick delayed copy.
- States:
  - RUN: phase increments each tick and wraps at SLOW_DIV-1.
    - fast=1: step_en=1 every tick.
    - fast=0: step_en=1 only on ticks where phase==SLOW_DIV-1.
  - TURN: lasts exactly one tick with step_en=0 and phase<=0, then returns to RUN.
  - PAUSE: step_en=0 and phase is held at 0. sstep_rise produces step_en=1 for exactly one tick.
- Transitions:
  - RUN -> TURN when deb_up != step_up. On that tick: step_up<=deb_up, dir_chg=1, step_en=0.
  - RUN or TURN -> PAUSE on hold_rise. step_en=0 on that tick; running drops on the same edge.
  - PAUSE -> RUN on hold_rise. phase<=0, so the first slow step comes SLOW_DIV ticks after resume. The first fast step comes on the next tick.
  - PAUSE with deb_up != step_up: step_up<=deb_up and dir_chg=1, with no TURN. The state stays PAUSE.
- Simultaneous events:
  - hold_rise and direction change in RUN: go to PAUSE, commit the direction, pulse dir_chg.
  - hold_rise and sstep_rise in PAUSE: hold wins. Go to RUN, no single step.
  - sstep_rise and direction change in PAUSE: commit the direction first, then step_en=1 with the new step_up on the same tick.
  - Mode change (fast toggles) in RUN: phase is not cleared. A slow step fires the next time phase==SLOW_DIV-1.
- step_en is never asserted on the same tick as dir_chg, except for a single step in PAUSE.
- Held buttons produce no further edges; there is no auto-repeat.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). After reset deasserts, a 3-tick conditioning settle applies before any switch change is honoured.
- phase width: $clog2(SLOW_DIV) bits.

Test Plan:
- Reset, then time_s=1, up=1, 10 ticks -> step_en=1 on every tick from the 4th edge onward, step_up=1, running=1, dir_chg never asserted.
- time_s=0, SLOW_DIV=2, 12 ticks -> step_en on alternating ticks: exactly 1 strobe in every 2-tick window after settle, fast=0.
- In fast RUN, flip up 1->0 -> exactly one tick with dir_chg=1 and step_en=0, then one TURN tick with step_en=0, then step_en=1 each tick with step_up=0.
- Pulse hold for 4 ticks -> running=0, step_en=0 for the entire pause. Pulse sstep twice -> exactly 2 single-tick step_en pulses. Pulse hold again -> running=1, stepping resumes.
- Assert hold and sstep together while paused -> running=1, and no single step_en pulse is generated from sstep.
- Assert reset mid-RUN with step_up=0 -> within the same cycle step_en=0, step_up=1, running=1, fast=0. No step for the first 3 edges after release.
